array_shift_ctrl: RTL and testbench
===================================

ARRAY_SHIFT_CTRL -- requirements
Module: array_shift_ctrl

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, data and index width.
REQ-002 SHALL have parameter NArea, default 10, words per array area on the heap.
REQ-003 SHALL have parameter AddrWidth, default 16, heap address width.
REQ-004 SHALL have port clock, input, 1, single clock, all state on posedge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request an insert; sampled only in IDLE.
REQ-007 SHALL have port array, input, MemoryElementWidth, target array number.
REQ-008 SHALL have port pos, input, MemoryElementWidth, insert index.
REQ-009 SHALL have port value, input, MemoryElementWidth, value to insert.
REQ-010 SHALL have port sizeIn, input, MemoryElementWidth, current size of the array; valid in the start cycle.
REQ-011 SHALL have port memAddr, output, AddrWidth, heap address.
REQ-012 SHALL have port memWe, output, 1, heap write enable.
REQ-013 SHALL have port memWData, output, MemoryElementWidth, heap write data.
REQ-014 SHALL have port memRData, input, MemoryElementWidth, heap read data; valid one cycle after memAddr is presented with memWe=0.
REQ-015 SHALL have port sizeWe, output, 1, one-cycle strobe to update the size table.
REQ-016 SHALL have port sizeOut, output, MemoryElementWidth, new size; valid while sizeWe=1.
REQ-017 SHALL have port busy, output, 1, high from the cycle after start acceptance until done.
REQ-018 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-019 SHALL have port error, output, 1, valid with done; request rejected.

Function
REQ-020 SHALL implement the states IDLE, CHECK, READ, WRITE, INSERT, SIZE and DONE.
REQ-021 In IDLE with start=1, SHALL latch array, pos, value and sizeIn, then enter CHECK; cycle of acceptance = cycle 0.
REQ-022 SHALL compute base = array*NArea, truncated to AddrWidth.
REQ-023 CHECK: if sizeIn >= NArea (full) or pos > sizeIn, SHALL go to DONE with error=1 and SHALL perform no memory or size write.
REQ-024 CHECK otherwise: SHALL set index i = sizeIn, then go to INSERT if i == pos, else to READ.
REQ-025 READ: SHALL drive memAddr = base+i-1 with memWe=0.
REQ-026 WRITE: SHALL drive memAddr = base+i, memWData = memRData, memWe=1, then decrement i; SHALL go to INSERT if the new i == pos, else to READ.
REQ-027 Elements SHALL move highest index first, so no element is overwritten before it is read.
REQ-028 INSERT: SHALL drive memAddr = base+pos, memWData = value, memWe=1.
REQ-029 SIZE: SHALL drive sizeWe=1 and sizeOut = sizeIn+1.
REQ-030 DONE: SHALL pulse done=1 for one cycle, hold error for that cycle, then return to IDLE.
REQ-031 Latency SHALL be done at cycle 4 + 2*(sizeIn-pos) after acceptance; a rejected request SHALL give done at cycle 2.
REQ-032 memWe SHALL be 0 in every state except WRITE and INSERT; sizeWe SHALL be 0 except in SIZE.
REQ-033 start while busy or in DONE SHALL be ignored, not queued.
REQ-034 start held high SHALL be accepted again in the first IDLE cycle after DONE.
REQ-035 Heap words outside base+pos .. base+sizeIn SHALL never be written.

Reset
REQ-036 While reset=1, SHALL be in IDLE with busy, done, error, memWe and sizeWe = 0, and memAddr, memWData and sizeOut = 0.
REQ-037 Reset asserted mid-operation SHALL abort immediately, asynchronously deassert memWe and sizeWe, and SHALL NOT pulse done; partially shifted heap contents are then undefined.

Verification
REQ-038 Array 1 = {0,1,2}, sizeIn 3, pos 2, value 99 -> heap[10..13] = {0,1,99,2}, sizeOut 4, done at cycle 6, error 0.
REQ-039 Same array, pos 0, value 7 -> heap[10..13] = {7,0,1,2}, done at cycle 10.
REQ-040 pos == sizeIn == 3 (append) -> no READ cycle, single write heap[13] = value, done at cycle 4.
REQ-041 sizeIn 10 (full) -> done and error at cycle 2, no memWe and no sizeWe; sizeIn 3 with pos 5 -> same.
REQ-042 Reset asserted at cycle 3 of the REQ-039 case -> memWe drops immediately, no done, and the block is in IDLE and accepts a new start after release.
REQ-043 start held high across two requests -> second request accepted the cycle after the first done, and start pulses during busy are ignored.

Source files
------------

// File: rtl/array_shift_ctrl.sv
// Inserts a value into an array that lives in a fixed-size heap area. The tail is
// shifted up one word, highest index first, and then the array's size is bumped.
module array_shift_ctrl #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 10,
  parameter int AddrWidth          = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [MemoryElementWidth-1:0] array,
  input  logic [MemoryElementWidth-1:0] pos,
  input  logic [MemoryElementWidth-1:0] value,
  input  logic [MemoryElementWidth-1:0] sizeIn,
  output logic [AddrWidth-1:0]          memAddr,
  output logic                          memWe,
  output logic [MemoryElementWidth-1:0] memWData,
  input  logic [MemoryElementWidth-1:0] memRData,
  output logic                          sizeWe,
  output logic [MemoryElementWidth-1:0] sizeOut,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam int W = MemoryElementWidth;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] READ   = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] INSERT = 3'd4;
  localparam logic [2:0] SIZE   = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  localparam logic [W-1:0]         NAREA_W  = W'(NArea);
  localparam logic [W-1:0]         ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [AddrWidth-1:0] ADDR_ONE = {{(AddrWidth-1){1'b0}}, 1'b1};

  // The product is formed wide and truncated, so the base wraps modulo 2**AddrWidth.
  function automatic logic [AddrWidth-1:0] area_base(input logic [W-1:0] arr);
    logic [AddrWidth+31:0] prod;
    prod = (AddrWidth+32)'(arr) * (AddrWidth+32)'(NArea);
    return prod[AddrWidth-1:0];
  endfunction

  function automatic logic [AddrWidth-1:0] heap_addr(input logic [AddrWidth-1:0] base,
                                                     input logic [W-1:0]         idx);
    return base + AddrWidth'(idx);
  endfunction

  logic [2:0]           state_q, state_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic [W-1:0]         pos_q, pos_d;
  logic [W-1:0]         value_q, value_d;
  logic [W-1:0]         size_q, size_d;
  logic [W-1:0]         idx_q, idx_d;
  logic                 err_q, err_d;

  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_we_q, mem_we_d;
  logic                 wr_from_rd_q, wr_from_rd_d;
  logic [W-1:0]         wdata_q, wdata_d;
  logic                 size_we_q, size_we_d;
  logic [W-1:0]         size_out_q, size_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic                 reject_s;

  assign reject_s = (size_q >= NAREA_W) || (pos_q > size_q);

  // Sequencer: latch the request, validate it, then walk i down from size to pos.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    pos_d   = pos_q;
    value_d = value_q;
    size_d  = size_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = area_base(array);
          pos_d   = pos;
          value_d = value;
          size_d  = sizeIn;
          err_d   = 1'b0;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (reject_s) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = size_q;
          if (size_q == pos_q) begin
            state_d = INSERT;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        state_d = WRITE;
      end
      WRITE: begin
        idx_d = idx_q - ONE_W;
        if (idx_d == pos_q) begin
          state_d = INSERT;
        end else begin
          state_d = READ;
        end
      end
      INSERT: begin
        state_d = SIZE;
      end
      SIZE: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values are decoded from the next state so they register in step with it.
  always_comb begin
    mem_addr_d   = {AddrWidth{1'b0}};
    mem_we_d     = 1'b0;
    wr_from_rd_d = 1'b0;
    wdata_d      = {W{1'b0}};
    size_we_d    = 1'b0;
    size_out_d   = {W{1'b0}};
    done_d       = 1'b0;
    error_d      = 1'b0;
    case (state_d)
      READ: begin
        mem_addr_d = heap_addr(base_q, idx_d) - ADDR_ONE;
      end
      WRITE: begin
        mem_addr_d   = heap_addr(base_q, idx_d);
        mem_we_d     = 1'b1;
        wr_from_rd_d = 1'b1;
      end
      INSERT: begin
        mem_addr_d = heap_addr(base_q, pos_q);
        mem_we_d   = 1'b1;
        wdata_d    = value_q;
      end
      SIZE: begin
        size_we_d  = 1'b1;
        size_out_d = size_q + ONE_W;
      end
      DONE: begin
        done_d  = 1'b1;
        error_d = err_d;
      end
      default: begin
        mem_we_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  // Control state and latched request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= {AddrWidth{1'b0}};
      pos_q   <= {W{1'b0}};
      value_q <= {W{1'b0}};
      size_q  <= {W{1'b0}};
      idx_q   <= {W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      pos_q   <= pos_d;
      value_q <= value_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Output registers; reset clears strobes immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr_q   <= {AddrWidth{1'b0}};
      mem_we_q     <= 1'b0;
      wr_from_rd_q <= 1'b0;
      wdata_q      <= {W{1'b0}};
      size_we_q    <= 1'b0;
      size_out_q   <= {W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      wr_from_rd_q <= wr_from_rd_d;
      wdata_q      <= wdata_d;
      size_we_q    <= size_we_d;
      size_out_q   <= size_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Read data arrives in the WRITE cycle itself, so the shifted word bypasses the registers.
  assign memWData = wr_from_rd_q ? memRData : wdata_q;
  assign memAddr  = mem_addr_q;
  assign memWe    = mem_we_q;
  assign sizeWe   = size_we_q;
  assign sizeOut  = size_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_array_shift_ctrl.sv
// Scoreboard bench for array_shift_ctrl: a driver queues expectations from a
// queue-based insert model, a negedge monitor checks the heap, strobes and latency.
module tb_array_shift_ctrl;

  localparam int W    = 12;
  localparam int NA   = 10;
  localparam int AW   = 16;
  localparam int HEAP = 256;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  array = '0, pos = '0, value = '0, sizeIn = '0;
  logic [W-1:0]  memRData = '0;
  logic [AW-1:0] memAddr;
  logic          memWe, sizeWe, busy, done, error;
  logic [W-1:0]  memWData, sizeOut;

  array_shift_ctrl #(.MemoryElementWidth(W), .NArea(NA), .AddrWidth(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .array(array), .pos(pos),
    .value(value), .sizeIn(sizeIn), .memAddr(memAddr), .memWe(memWe),
    .memWData(memWData), .memRData(memRData), .sizeWe(sizeWe), .sizeOut(sizeOut),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int       acc;
    int       due;
    bit       err;
    logic [W-1:0] new_size;
    int       base;
    int       lo;
    int       hi;
    int       n_writes;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] mem [HEAP];
  logic [W-1:0] ref_heap [HEAP];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  bit           abort_ok = 1'b0;
  int           wr_cnt = 0;
  int           sz_cnt = 0;
  exp_t         mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Heap with one-cycle read latency
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (memWe) mem[memAddr[7:0]] <= memWData;
    else       memRData <= mem[memAddr[7:0]];
  end

  // Monitor: pops the scoreboard on done, polices every write and size strobe
  always @(negedge clock) begin
    if (!reset) begin
      if (memWe) begin
        if (sb.size() == 0) begin
          if (!abort_ok) check("stray_memWe", {63'd0, memWe}, 64'd0);
        end else begin
          wr_cnt++;
          check("write_in_range",
                {63'd0, (int'(memAddr) >= sb[0].base + sb[0].lo) && (int'(memAddr) <= sb[0].base + sb[0].hi)},
                64'd1);
        end
      end
      if (sizeWe) begin
        if (sb.size() == 0) begin
          check("stray_sizeWe", {63'd0, sizeWe}, 64'd0);
        end else begin
          sz_cnt++;
          check("sizeOut", {52'd0, sizeOut}, {52'd0, sb[0].new_size});
          check("sizeWe_cycle", 64'(cyc), 64'(sb[0].due - 1));
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("stray_done", {63'd0, done}, 64'd0);
        end else begin
          int bad;
          mon_e = sb.pop_front();
          check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.due - mon_e.acc));
          check("error", {63'd0, error}, {63'd0, mon_e.err});
          check("write_count", 64'(wr_cnt), mon_e.err ? 64'd0 : 64'(mon_e.n_writes));
          check("sizeWe_count", 64'(sz_cnt), mon_e.err ? 64'd0 : 64'd1);
          bad = -1;
          for (int i = 0; i < HEAP; i++) if (bad < 0 && mem[i] !== ref_heap[i]) bad = i;
          if (bad < 0) bad = (mon_e.base + mon_e.lo) % HEAP;
          check($sformatf("heap[%0d]", bad), {52'd0, mem[bad]}, {52'd0, ref_heap[bad]});
        end
        wr_cnt = 0;
        sz_cnt = 0;
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        check("done_timeout", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
        wr_cnt = 0;
        sz_cnt = 0;
      end
    end
  end

  task automatic load3(input int arr, input int a, input int b, input int c);
    int base;
    base = arr * NA;
    mem[base] = W'(a);   mem[base+1] = W'(b);   mem[base+2] = W'(c);
    ref_heap[base] = W'(a); ref_heap[base+1] = W'(b); ref_heap[base+2] = W'(c);
  endtask

  // Issue one request at a negedge; returns at the negedge of the first IDLE cycle after done.
  task automatic issue(input int arr, input int p, input int v, input int sz,
                       input bit hold_after, input bit noise);
    exp_t e;
    int lat;
    logic [W-1:0] q[$];
    array = W'(arr); pos = W'(p); value = W'(v); sizeIn = W'(sz); start = 1'b1;
    e.acc = cyc;
    e.base = arr * NA;
    e.lo = p;
    e.hi = sz;
    e.err = (sz >= NA) || (p > sz);
    e.n_writes = sz - p + 1;
    e.new_size = W'(sz + 1);
    lat = e.err ? 2 : 4 + 2 * (sz - p);
    e.due = e.acc + lat;
    if (!e.err) begin
      q = {};
      for (int k = 0; k < sz; k++) q.push_back(ref_heap[e.base + k]);
      q.insert(p, W'(v));
      for (int k = 0; k <= sz; k++) ref_heap[e.base + k] = q[k];
    end
    sb.push_back(e);
    @(negedge clock);
    for (int k = 1; k <= lat; k++) begin
      if (noise && k < lat) begin
        start = 1'($urandom_range(1, 0));
        array = W'($urandom); pos = W'($urandom); value = W'($urandom); sizeIn = W'($urandom);
      end else begin
        start = hold_after;
      end
      @(negedge clock);
    end
    start = hold_after;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < HEAP; i++) begin
      mem[i] = W'($urandom);
      ref_heap[i] = mem[i];
    end
    repeat (3) @(negedge clock);
    check("reset_outputs", {23'd0, busy, done, error, memWe, sizeWe, memAddr, memWData, sizeOut},
          64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed cases on array 1 = {0,1,2}
    load3(1, 0, 1, 2);
    issue(1, 2, 99, 3, 1'b0, 1'b0);
    check("mid_insert_heap", {16'd0, mem[10], mem[11], mem[12], mem[13]}, {16'd0, 12'd0, 12'd1, 12'd99, 12'd2});
    load3(1, 0, 1, 2);
    issue(1, 0, 7, 3, 1'b0, 1'b0);
    check("front_insert_heap", {16'd0, mem[10], mem[11], mem[12], mem[13]}, {16'd0, 12'd7, 12'd0, 12'd1, 12'd2});
    load3(1, 0, 1, 2);
    issue(1, 3, 55, 3, 1'b0, 1'b0);
    check("append_heap", {16'd0, mem[10], mem[11], mem[12], mem[13]}, {16'd0, 12'd0, 12'd1, 12'd2, 12'd55});
    issue(1, 0, 5, 10, 1'b0, 1'b0);
    issue(1, 5, 5, 3, 1'b0, 1'b0);

    // Abort the front-insert case with reset during its first WRITE cycle
    load3(1, 0, 1, 2);
    abort_ok = 1'b1;
    array = 12'd1; pos = 12'd0; value = 12'd7; sizeIn = 12'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("abort_we_before", {63'd0, memWe}, 64'd1);
    reset = 1'b1;
    #1;
    check("abort_we_dropped", {61'd0, memWe, sizeWe, done}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < HEAP; i++) ref_heap[i] = mem[i];
    reset = 1'b0;
    @(negedge clock);
    check("abort_idle_busy", {63'd0, busy}, 64'd0);
    abort_ok = 1'b0;
    load3(1, 0, 1, 2);
    issue(1, 1, 33, 3, 1'b0, 1'b0);

    // Start held high across two back-to-back requests
    load3(2, 4, 5, 6);
    issue(2, 1, 77, 3, 1'b1, 1'b0);
    issue(2, 0, 88, 4, 1'b0, 1'b0);

    // Random requests with ignored start pulses while busy
    for (int t = 0; t < 40; t++) begin
      int arr, sz, p;
      arr = $urandom_range(24, 0);
      sz  = $urandom_range(11, 0);
      if ($urandom_range(4, 0) == 0) p = sz + $urandom_range(3, 1);
      else                           p = $urandom_range(sz, 0);
      issue(arr, p, $urandom_range(4095, 0), sz, 1'b0, 1'b1);
      if ($urandom_range(1, 0) == 1) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
